fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the instruction ROM. Holds the PC and drives the ROM read address. Captures the ROM's registered response, reorders its bytes into a little-endian instruction word, and buffers {pc, inst} pairs in a small FIFO for the decode stage. Handles redirects (jump/branch flush) and address-window faults.

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch top and its fetch buffer.
package fetch_unit_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO        = '0;
    localparam logic [ADDR_W-1:0] FETCH_RESET_PC  = 64'h0000_0000_8000_0000;
    localparam logic [ADDR_W-1:0] FETCH_ROM_BASE  = 64'h0000_0000_8000_0000;
    localparam logic [ADDR_W-1:0] FETCH_ROM_LIMIT = 64'h0000_0000_8FFF_FFFF;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer holding {pc, inst} pairs for decode.
// Head is read straight from storage registers; flush empties it.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         push,
    input  fetch_entry_t wdata,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         valid,
    output logic [CW-1:0] count
);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage, pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry and non-empty flag.
    always_comb begin
        head  = mem[rd_ptr];
        valid = (count != '0);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM request, byte reorder, fetch buffer.
// Handles redirects and faults on fetches outside the ROM window.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [63:0] RESET_PC   = FETCH_RESET_PC,
    parameter logic [63:0] ROM_BASE   = FETCH_ROM_BASE,
    parameter logic [63:0] ROM_LIMIT  = FETCH_ROM_LIMIT
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic [63:0] ReadAddrOut,
    input  logic [31:0] ReadDataIn,
    input  logic        RomReady,
    input  logic        JumpFlag,
    input  logic [63:0] JumpAddr,
    input  logic        InstReady,
    output logic        InstValid,
    output logic [31:0] InstOut,
    output logic [63:0] InstAddrOut,
    output logic        FetchFault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e state;
    fetch_state_e state_nxt;
    logic [63:0]  pc;
    logic [63:0]  pc_nxt;
    logic [63:0]  req_pc;
    logic [63:0]  req_pc_nxt;
    logic         inflight;
    logic         inflight_nxt;

    logic          push;
    logic          pop;
    logic          flush;
    logic [CW-1:0] count;
    logic [CW:0]   used;
    logic          credit;
    logic          stall;
    logic [63:0]   jump_pc;
    fetch_entry_t  wdata;
    fetch_entry_t  head;
    logic          unused_jump_bits;

    // Whole word must sit inside the ROM window; 0 is the ROM idle code.
    function automatic logic legal(input logic [63:0] addr);
        logic [64:0] last;
        last = {1'b0, addr} + 65'd3;
        return (addr != REG_ZERO) && (addr >= ROM_BASE) &&
               (last <= {1'b0, ROM_LIMIT});
    endfunction

    // ROM returns M[a] in the top byte; decode wants it in the bottom.
    function automatic logic [31:0] byteswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    assign jump_pc          = {JumpAddr[63:2], 2'b00};
    assign unused_jump_bits = ^JumpAddr[1:0];
    assign stall            = inflight && !RomReady;
    assign used             = {1'b0, count} + (CW+1)'(inflight);
    assign credit           = used < (CW+1)'(FIFO_DEPTH);
    assign wdata            = '{pc: req_pc, inst: byteswap(ReadDataIn)};
    assign FetchFault       = (state == FETCH_FAULT);
    assign InstOut          = head.inst;
    assign InstAddrOut      = head.pc;

    // State, PC and the single outstanding request.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= FETCH_IDLE;
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_pc   <= req_pc_nxt;
            inflight <= inflight_nxt;
        end
    end

    // Redirect first, then issue/stall/fault decisions per state.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_pc_nxt   = req_pc;
        inflight_nxt = inflight;
        push         = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        ReadAddrOut  = REG_ZERO;
        if (JumpFlag) begin
            flush        = 1'b1;
            inflight_nxt = 1'b0;
            pc_nxt       = jump_pc;
            state_nxt    = legal(jump_pc) ? FETCH_RUN : FETCH_FAULT;
        end else begin
            push = inflight && RomReady;
            pop  = InstValid && InstReady;
            unique case (state)
                FETCH_IDLE: begin
                    state_nxt = legal(pc) ? FETCH_RUN : FETCH_FAULT;
                end
                FETCH_RUN: begin
                    if (stall) begin
                        ReadAddrOut = req_pc;
                    end else if (credit && legal(pc)) begin
                        ReadAddrOut  = pc;
                        pc_nxt       = pc + 64'd4;
                        req_pc_nxt   = pc;
                        inflight_nxt = 1'b1;
                    end else begin
                        inflight_nxt = 1'b0;
                        if (!legal(pc)) begin
                            state_nxt = FETCH_FAULT;
                        end
                    end
                end
                FETCH_FAULT: begin
                    inflight_nxt = 1'b0;
                end
                default: begin
                    state_nxt = FETCH_IDLE;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .flush (flush),
        .head  (head),
        .valid (InstValid),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a queue-based reference model.
// Directed phases pin reset, redirect, fault and window-edge behaviour.
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] LIMIT = 64'h0000_0000_8FFF_FFFF;
    localparam logic [63:0] RPC   = 64'h0000_0000_8000_0000;

    logic        Clk;
    logic        Rst;
    logic [63:0] ReadAddrOut;
    logic [31:0] ReadDataIn;
    logic        RomReady;
    logic        JumpFlag;
    logic [63:0] JumpAddr;
    logic        InstReady;
    logic        InstValid;
    logic [31:0] InstOut;
    logic [63:0] InstAddrOut;
    logic        FetchFault;

    int n_chk  = 0;
    int n_fail = 0;

    int rom_pct  = 100;
    int spur_pct = 0;
    logic [63:0] rom_req = '0;

    // Reference model: 0 idle, 1 run, 2 fault.
    int          m_state   = 0;
    logic [63:0] m_pc      = RPC;
    bit          m_pend    = 0;
    logic [63:0] m_pend_pc = '0;
    logic [63:0] q_pc[$];
    logic [31:0] q_inst[$];

    fetch_unit #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .ReadAddrOut (ReadAddrOut),
        .ReadDataIn  (ReadDataIn),
        .RomReady    (RomReady),
        .JumpFlag    (JumpFlag),
        .JumpAddr    (JumpAddr),
        .InstReady   (InstReady),
        .InstValid   (InstValid),
        .InstOut     (InstOut),
        .InstAddrOut (InstAddrOut),
        .FetchFault  (FetchFault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Byte image of the ROM: one known instruction at the base.
    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        logic [31:0] h;
        if (a == 64'h8000_0000) return 8'h13;
        if (a >= 64'h8000_0001 && a <= 64'h8000_0003) return 8'h00;
        h = a[31:0] * 32'h9E37_79B1;
        return h[31:24] ^ h[7:0];
    endfunction

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        return {mem_byte(a), mem_byte(a + 1), mem_byte(a + 2), mem_byte(a + 3)};
    endfunction

    function automatic logic [31:0] le_word(input logic [63:0] a);
        return {mem_byte(a + 3), mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)};
    endfunction

    function automatic bit ok_addr(input logic [63:0] a);
        return a != 0 && a >= BASE && a <= LIMIT - 3;
    endfunction

    task automatic model_reset();
        m_state   = 0;
        m_pc      = RPC;
        m_pend    = 0;
        m_pend_pc = '0;
        q_pc.delete();
        q_inst.delete();
        rom_req   = '0;
    endtask

    // ROM: registered response to the address seen at the previous edge.
    always @(posedge Clk) begin
        #1;
        if (rom_req != 0 && $urandom_range(0, 99) < rom_pct) begin
            RomReady   = 1'b1;
            ReadDataIn = rom_word(rom_req);
        end else if (rom_req == 0 && $urandom_range(0, 99) < spur_pct) begin
            RomReady   = 1'b1;
            ReadDataIn = $urandom;
        end else begin
            RomReady   = 1'b0;
            ReadDataIn = $urandom;
        end
    end

    // Compare every cycle against the model, then advance the model.
    always @(negedge Clk or negedge Rst) begin : cmp
        bit          vld;
        bit          stall;
        bit          issue;
        int          used;
        logic [63:0] ea;
        if (!Rst) begin
            model_reset();
        end else begin
            vld   = q_pc.size() != 0;
            used  = q_pc.size() + (m_pend ? 1 : 0);
            stall = m_pend && !RomReady;
            issue = 0;
            ea    = '0;
            chk("valid", InstValid, vld);
            if (vld) begin
                chk("inst_addr", InstAddrOut, q_pc[0]);
                chk("inst", InstOut, q_inst[0]);
            end
            chk("fault", FetchFault, m_state == 2);
            if (!JumpFlag && m_state == 1) begin
                if (stall) begin
                    ea = m_pend_pc;
                end else if (used < DEPTH && ok_addr(m_pc)) begin
                    ea    = m_pc;
                    issue = 1;
                end
            end
            chk("read_addr", ReadAddrOut, ea);
            rom_req = ReadAddrOut;
            if (JumpFlag) begin
                q_pc.delete();
                q_inst.delete();
                m_pend  = 0;
                m_pc    = {JumpAddr[63:2], 2'b00};
                m_state = ok_addr(m_pc) ? 1 : 2;
            end else begin
                if (vld && InstReady) begin
                    void'(q_pc.pop_front());
                    void'(q_inst.pop_front());
                end
                if (m_pend && RomReady) begin
                    q_pc.push_back(m_pend_pc);
                    q_inst.push_back(le_word(m_pend_pc));
                end
                if (m_state == 0) begin
                    m_state = ok_addr(m_pc) ? 1 : 2;
                end else if (m_state == 1) begin
                    if (issue) begin
                        m_pend    = 1;
                        m_pend_pc = m_pc;
                        m_pc      = m_pc + 4;
                    end else if (!stall) begin
                        m_pend = 0;
                        if (!ok_addr(m_pc)) m_state = 2;
                    end
                end
            end
        end
    end

    task automatic cyc(input logic jf, input logic [63:0] ja, input logic ir);
        @(posedge Clk);
        #1;
        JumpFlag  = jf;
        JumpAddr  = ja;
        InstReady = ir;
    endtask

    task automatic at_neg();
        @(negedge Clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_addr"}, ReadAddrOut, 64'h0);
        chk({tag, "_valid"}, InstValid, 1'b0);
        chk({tag, "_inst"}, InstOut, 32'h0);
        chk({tag, "_iaddr"}, InstAddrOut, 64'h0);
        chk({tag, "_fault"}, FetchFault, 1'b0);
    endtask

    function automatic logic [63:0] rand_target();
        int k;
        k = $urandom_range(0, 9);
        if (k < 6) return BASE + 64'({$urandom_range(0, 255), 2'b00}) + 64'($urandom_range(0, 3));
        if (k < 8) return 64'h8FFF_FFE0 + 64'($urandom_range(0, 31));
        if (k == 8) return 64'h0;
        return ($urandom_range(0, 1) == 1) ? 64'h9000_0000 : 64'h7FFF_FFFC;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Rst        = 1'b0;
        JumpFlag   = 1'b0;
        JumpAddr   = '0;
        InstReady  = 1'b1;
        RomReady   = 1'b0;
        ReadDataIn = '0;
        #1;
        chk_zero_outputs("reset");

        // Release mid-cycle: this cycle is T0.
        @(posedge Clk);
        #2;
        Rst = 1'b1;
        at_neg();
        chk("t0_addr", ReadAddrOut, 64'h0);
        cyc(0, 0, 1);
        at_neg();
        chk("t1_addr", ReadAddrOut, 64'h8000_0000);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        at_neg();
        chk("t3_valid", InstValid, 1'b1);
        chk("t3_inst", InstOut, 32'h0000_0013);
        chk("t3_iaddr", InstAddrOut, 64'h8000_0000);
        cyc(0, 0, 1);
        at_neg();
        chk("t4_iaddr", InstAddrOut, 64'h8000_0004);
        cyc(0, 0, 1);
        at_neg();
        chk("t5_iaddr", InstAddrOut, 64'h8000_0008);

        // Decode back-pressure: buffer fills, requests stop.
        for (int i = 0; i < 12; i++) cyc(0, 0, 0);
        at_neg();
        chk("full_addr", ReadAddrOut, 64'h0);
        chk("full_valid", InstValid, 1'b1);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1);

        // Redirect with two entries buffered and one request in flight.
        cyc(1, 64'h8000_0200, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        cyc(1, 64'h8000_0102, 0);
        at_neg();
        chk("half_valid", InstValid, 1'b1);
        cyc(0, 0, 0);
        at_neg();
        chk("jr1_valid", InstValid, 1'b0);
        chk("jr1_addr", ReadAddrOut, 64'h8000_0100);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        at_neg();
        chk("jr3_valid", InstValid, 1'b1);
        chk("jr3_iaddr", InstAddrOut, 64'h8000_0100);

        // Illegal redirect targets, then recovery.
        cyc(1, 64'h0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1);
            at_neg();
            chk("j0_fault", FetchFault, 1'b1);
            chk("j0_addr", ReadAddrOut, 64'h0);
        end
        cyc(1, 64'h9000_0000, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1);
            at_neg();
            chk("j9_fault", FetchFault, 1'b1);
            chk("j9_addr", ReadAddrOut, 64'h0);
        end
        cyc(1, 64'h8000_0000, 1);
        cyc(0, 0, 1);
        at_neg();
        chk("resume_fault", FetchFault, 1'b0);
        chk("resume_addr", ReadAddrOut, 64'h8000_0000);

        // Run up to the top of the ROM window.
        cyc(1, 64'h8FFF_FFF0, 1);
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 1);
            at_neg();
            chk("no_req_9000", ReadAddrOut == 64'h9000_0000, 1'b0);
            if (k == 5) chk("wrap_fault_pre", FetchFault, 1'b0);
            if (k == 6) begin
                chk("wrap_fault", FetchFault, 1'b1);
                chk("wrap_valid", InstValid, 1'b1);
                chk("wrap_iaddr", InstAddrOut, 64'h8FFF_FFFC);
            end
        end

        // Random traffic with ROM stalls and stray ready pulses.
        rom_pct  = 70;
        spur_pct = 10;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) < 3) cyc(1, rand_target(), $urandom_range(0, 99) < 60);
            else cyc(0, 0, $urandom_range(0, 99) < 60);
        end

        // Asynchronous reset between edges, then restart timing.
        rom_pct  = 100;
        spur_pct = 0;
        cyc(0, 0, 1);
        #1;
        Rst = 1'b0;
        #1;
        chk_zero_outputs("mid_reset");
        #1;
        Rst = 1'b1;
        at_neg();
        chk("r_t0_addr", ReadAddrOut, 64'h0);
        cyc(0, 0, 1);
        at_neg();
        chk("r_t1_addr", ReadAddrOut, 64'h8000_0000);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        at_neg();
        chk("r_t3_valid", InstValid, 1'b1);
        chk("r_t3_inst", InstOut, 32'h0000_0013);
        chk("r_t3_iaddr", InstAddrOut, 64'h8000_0000);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1);

        at_neg();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
